// File: rtl/cnu_serial_minsum_if.sv
// Handshake bundle for the serial min-sum check node unit: variable-to-check
// input stream, check-to-variable output stream and the parity status bit.
interface cnu_serial_minsum_if #(
  parameter int DC    = 6,
  parameter int MAG_W = 4,
  parameter int IDX_W = $clog2(DC)
);

  logic             in_valid;
  logic             in_ready;
  logic [MAG_W+1:0] in_msg;
  logic             out_valid;
  logic             out_ready;
  logic [MAG_W:0]   out_msg;
  logic [IDX_W-1:0] out_idx;
  logic             p_bit;

  modport slave (
    input  in_valid,
    input  in_msg,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_msg,
    output out_idx,
    output p_bit
  );

  modport master (
    output in_valid,
    output in_msg,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_msg,
    input  out_idx,
    input  p_bit
  );

endinterface

// File: rtl/cnu_serial_minsum.sv
// Serial min-sum check node: collects DC messages, then emits DC extrinsic replies.
// Optional offset min-sum output stage is compiled in with CNU_OFFSET_EN.
module cnu_serial_minsum #(
  parameter int DC     = 6,
  parameter int MAG_W  = 4,
  parameter int OFFSET = 1,
  parameter int IDX_W  = $clog2(DC)
) (
  input logic                 clk,
  input logic                 rst,
  cnu_serial_minsum_if.slave  io_bus
);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DC - 1);
  localparam logic [MAG_W-1:0] MAG_MAX  = '1;
  localparam logic [MAG_W-1:0] OFF_M    = MAG_W'(OFFSET);

`ifdef CNU_OFFSET_EN
  localparam bit OFFSET_EN = 1'b1;
`else
  localparam bit OFFSET_EN = 1'b0;
`endif

  state_t           r_state;
  state_t           w_nextState;
  logic [IDX_W-1:0] r_k;
  logic [IDX_W-1:0] r_j;
  logic [MAG_W-1:0] r_min1;
  logic [MAG_W-1:0] r_min2;
  logic [IDX_W-1:0] r_idx;
  logic             r_sxor;
  logic             r_par;
  logic             r_pBit;
  logic [DC-1:0]    r_signs;

  logic             w_inReady;
  logic             w_outValid;
  logic             w_inFire;
  logic             w_outFire;
  logic             w_lastIn;
  logic             w_lastOut;
  logic [MAG_W-1:0] w_inMag;
  logic             w_inSign;
  logic             w_inHd;
  logic             w_ltMin1;
  logic             w_ltMin2;
  logic [MAG_W-1:0] w_selMag;
  logic [MAG_W-1:0] w_offMag;
  logic [MAG_W-1:0] w_outMag;
  logic             w_outSign;

  assign w_inMag  = io_bus.in_msg[MAG_W-1:0];
  assign w_inSign = io_bus.in_msg[MAG_W];
  assign w_inHd   = io_bus.in_msg[MAG_W+1];

  assign w_inFire  = io_bus.in_valid & w_inReady;
  assign w_outFire = w_outValid & io_bus.out_ready;
  assign w_lastIn  = (r_k == LAST_IDX);
  assign w_lastOut = (r_j == LAST_IDX);

  assign w_ltMin1 = (w_inMag < r_min1);
  assign w_ltMin2 = (w_inMag < r_min2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    case (r_state)
      COLLECT: begin
        w_inReady = 1'b1;
        if (io_bus.in_valid && w_lastIn) begin
          w_nextState = EMIT;
        end
      end
      EMIT: begin
        w_outValid = 1'b1;
        if (io_bus.out_ready && w_lastOut) begin
          w_nextState = COLLECT;
        end
      end
      default: begin
        w_nextState = COLLECT;
      end
    endcase
  end

  // Working registers are re-armed on the last output handshake so every check starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k     <= '0;
      r_j     <= '0;
      r_min1  <= MAG_MAX;
      r_min2  <= MAG_MAX;
      r_idx   <= '0;
      r_sxor  <= 1'b0;
      r_par   <= 1'b0;
      r_pBit  <= 1'b0;
      r_signs <= '0;
    end else begin
      if (w_inFire) begin
        r_signs[r_k] <= w_inSign;
        r_sxor       <= r_sxor ^ w_inSign;
        r_par        <= r_par ^ w_inHd;
        if (w_ltMin1) begin
          r_min2 <= r_min1;
          r_min1 <= w_inMag;
          r_idx  <= r_k;
        end else if (w_ltMin2) begin
          r_min2 <= w_inMag;
        end
        if (w_lastIn) begin
          r_k    <= '0;
          r_pBit <= r_par ^ w_inHd;
        end else begin
          r_k <= r_k + IDX_W'(1);
        end
      end
      if (w_outFire) begin
        if (w_lastOut) begin
          r_j    <= '0;
          r_min1 <= MAG_MAX;
          r_min2 <= MAG_MAX;
          r_idx  <= '0;
          r_sxor <= 1'b0;
          r_par  <= 1'b0;
        end else begin
          r_j <= r_j + IDX_W'(1);
        end
      end
    end
  end

  // The extrinsic reply excludes the receiver's own message, hence min2 at the min1 position.
  assign w_selMag  = (r_j == r_idx) ? r_min2 : r_min1;
  assign w_offMag  = (w_selMag > OFF_M) ? (w_selMag - OFF_M) : '0;
  assign w_outMag  = OFFSET_EN ? w_offMag : w_selMag;
  assign w_outSign = r_sxor ^ r_signs[r_j];

  assign io_bus.in_ready  = w_inReady;
  assign io_bus.out_valid = w_outValid;
  assign io_bus.out_msg   = w_outValid ? {w_outSign, w_outMag} : '0;
  assign io_bus.out_idx   = r_j;
  assign io_bus.p_bit     = r_pBit;

endmodule

// File: tb/tb_cnu_serial_minsum.sv
// Directed self-checking bench for cnu_serial_minsum (DC=6, MAG_W=4, OFFSET=1).
// Expected values are hand-computed; CNU_OFFSET_EN selects the offset variants.
module tb_cnu_serial_minsum;

  localparam int DC     = 6;
  localparam int MAG_W  = 4;
  localparam int OFFSET = 1;

  typedef logic [MAG_W-1:0] magArr_t [DC];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nChecks = 0;
  int   nPass   = 0;

  cnu_serial_minsum_if #(.DC(DC), .MAG_W(MAG_W)) bus ();

  cnu_serial_minsum #(
    .DC    (DC),
    .MAG_W (MAG_W),
    .OFFSET(OFFSET)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input magArr_t mags, input logic [DC-1:0] signs,
                               input logic [DC-1:0] hds, input bit holdValid);
    for (int i = 0; i < DC; i++) begin
      int waitCnt;
      waitCnt = 0;
      bus.in_valid = 1'b1;
      bus.in_msg   = {hds[i], signs[i], mags[i]};
      while (!bus.in_ready && waitCnt < 40) begin
        tick();
        waitCnt++;
      end
      checkOutput($sformatf("inReady%0d", i), 32'(bus.in_ready), 32'd1);
      tick();
    end
    bus.in_valid = holdValid;
  endtask

  task automatic collectOutputs(input string tag, input magArr_t expMags,
                                input logic [DC-1:0] expSigns, input logic expP,
                                input int stallAt);
    bus.out_ready = 1'b1;
    for (int j = 0; j < DC; j++) begin
      int waitCnt;
      waitCnt = 0;
      while (!bus.out_valid && waitCnt < 40) begin
        tick();
        waitCnt++;
      end
      checkOutput($sformatf("%s_valid%0d", tag, j), 32'(bus.out_valid), 32'd1);
      if (j == stallAt) begin
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_msg    = '1;
        for (int s = 0; s < 3; s++) begin
          tick();
          checkOutput($sformatf("%s_stallIdx%0d", tag, s), 32'(bus.out_idx), 32'(j));
          checkOutput($sformatf("%s_stallMsg%0d", tag, s), 32'(bus.out_msg),
                      32'({expSigns[j], expMags[j]}));
          checkOutput($sformatf("%s_stallInReady%0d", tag, s), 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
      end
      checkOutput($sformatf("%s_idx%0d", tag, j), 32'(bus.out_idx), 32'(j));
      checkOutput($sformatf("%s_mag%0d", tag, j), 32'(bus.out_msg[MAG_W-1:0]), 32'(expMags[j]));
      checkOutput($sformatf("%s_sign%0d", tag, j), 32'(bus.out_msg[MAG_W]), 32'(expSigns[j]));
      checkOutput($sformatf("%s_pbit%0d", tag, j), 32'(bus.p_bit), 32'(expP));
      tick();
    end
    checkOutput({tag, "_inReadyBack"}, 32'(bus.in_ready), 32'd1);
    checkOutput({tag, "_outValidLow"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_pbitHold"}, 32'(bus.p_bit), 32'(expP));
  endtask

  initial begin
    magArr_t m;
    magArr_t e;

    bus.in_valid  = 1'b0;
    bus.in_msg    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checkOutput("rstInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("rstOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstOutMsg", 32'(bus.out_msg), 32'd0);
    checkOutput("rstOutIdx", 32'(bus.out_idx), 32'd0);
    checkOutput("rstPbit", 32'(bus.p_bit), 32'd0);

    // out_ready is raised during COLLECT to show it has no effect there
    bus.out_ready = 1'b1;
    m = '{4'd5, 4'd3, 4'd7, 4'd2, 4'd9, 4'd4};
`ifdef CNU_OFFSET_EN
    e = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd1, 4'd1};
`else
    e = '{4'd2, 4'd2, 4'd2, 4'd3, 4'd2, 4'd2};
`endif
    applyStimulus(m, 6'b000000, 6'b001101, 1'b0);
    checkOutput("firstValidLatency", 32'(bus.out_valid), 32'd1);
    collectOutputs("magSel", e, 6'b000000, 1'b1, -1);

    applyStimulus(m, 6'b000100, 6'b000000, 1'b0);
    collectOutputs("signs", e, 6'b111011, 1'b0, -1);

    m = '{4'd0, 4'd0, 4'd6, 4'd6, 4'd6, 4'd6};
    e = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    applyStimulus(m, 6'b000000, 6'b000111, 1'b0);
    collectOutputs("ties", e, 6'b000000, 1'b1, -1);

    m = '{4'd5, 4'd3, 4'd7, 4'd2, 4'd9, 4'd4};
`ifdef CNU_OFFSET_EN
    e = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd1, 4'd1};
`else
    e = '{4'd2, 4'd2, 4'd2, 4'd3, 4'd2, 4'd2};
`endif
    applyStimulus(m, 6'b000000, 6'b001101, 1'b0);
    collectOutputs("backpr", e, 6'b000000, 1'b1, 2);

    // three inputs that would dominate the minima if they leaked past reset
    bus.in_valid = 1'b1;
    bus.in_msg   = {1'b1, 1'b1, 4'd0};
    repeat (3) tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #2;
    checkOutput("midRstPbit", 32'(bus.p_bit), 32'd0);
    checkOutput("midRstInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("midRstOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("midRstOutMsg", 32'(bus.out_msg), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    m = '{4'd8, 4'd12, 4'd10, 4'd9, 4'd15, 4'd11};
`ifdef CNU_OFFSET_EN
    e = '{4'd8, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7};
`else
    e = '{4'd9, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};
`endif
    applyStimulus(m, 6'b000110, 6'b000010, 1'b0);
    collectOutputs("afterRst", e, 6'b000110, 1'b1, -1);

    m = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
`ifdef CNU_OFFSET_EN
    e = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
`else
    e = '{4'd2, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
`endif
    applyStimulus(m, 6'b000000, 6'b000000, 1'b1);
    collectOutputs("b2bA", e, 6'b000000, 1'b0, -1);

    m = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
`ifdef CNU_OFFSET_EN
    e = '{4'd14, 4'd14, 4'd14, 4'd14, 4'd14, 4'd14};
`else
    e = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
`endif
    applyStimulus(m, 6'b111111, 6'b100000, 1'b0);
    collectOutputs("b2bB", e, 6'b111111, 1'b1, -1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/cnu_serial_minsum.md
# cnu_serial_minsum

Parametrised serial min-sum check node unit for the LDPC decoder. It accepts the DC variable-to-check messages of one check node one per cycle over a valid/ready handshake, and tracks the two smallest magnitudes, the position of the smallest, the sign XOR and the hard-decision parity. It then emits DC check-to-variable messages one per cycle over a second valid/ready handshake. It sits between the PE blocks and the check-node scheduler and replaces the fixed-degree parallel CNU wherever degree or message width must vary.

## Interface
- DC, 6: check node degree, number of messages per check; must be ≥ 2.
- MAG_W, 4: magnitude width of each message.
- OFFSET, 1: offset subtracted from output magnitudes when the offset feature is compiled in.
- IDX_W, $clog2(DC): index width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_msg is valid.
- in_ready  out  1  block accepts in_msg this cycle.
- in_msg  in  MAG_W+2  {hard decision, sign, magnitude[MAG_W-1:0]}.
- out_valid  out  1  out_msg is valid.
- out_ready  in  1  downstream accepts out_msg this cycle.
- out_msg  out  MAG_W+1  {sign, magnitude}.
- out_idx  out  IDX_W  position (0..DC-1) of the current out_msg.
- p_bit  out  1  XOR of the DC hard-decision bits of the last completed check.

## Operation
- Two states:
  - COLLECT: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- COLLECT, on each accept (in_valid & in_ready), with input counter k:
  - sign[k] stored.
  - sxor ^= sign.
  - par ^= hard decision.
  - Magnitude update:
    - if mag < min1: min2 ← min1, min1 ← mag, idx ← k.
    - else if mag < min2: min2 ← mag.
  - Comparisons are strict, so ties keep the earlier index. The second equal value still lands in min2 through the second comparison.
  - k increments. On accept with k = DC-1: k ← 0, p_bit ← final par, state ← EMIT.
- At entry to each COLLECT (reset or end of EMIT), the working registers are initialised:
  - min1 = min2 = 2^MAG_W-1.
  - sxor = par = 0.
  - idx = 0.
- EMIT, with output counter j:
  - out_idx = j.
  - out_msg sign = sxor ^ sign[j].
  - out_msg magnitude = (j == idx) ? min2 : min1, after the offset stage (see Configuration).
  - On handshake (out_valid & out_ready), j increments. On handshake with j = DC-1: j ← 0, state ← COLLECT.
- Holding rules:
  - out_msg and out_idx are stable while out_valid=1 and out_ready=0.
  - p_bit holds its value until the next transition into EMIT.
- Arithmetic:
  - All magnitude arithmetic is unsigned MAG_W bits.
  - The offset stage saturates at 0 and never wraps.

## Timing
- Reset values:
  - state = COLLECT; in_ready = 1; out_valid = 0.
  - out_msg = 0; out_idx = 0; p_bit = 0.
  - min1 = min2 = all ones; k = j = 0.
- Latency:
  - The first out_valid is asserted the cycle after the DC-th input is accepted.
  - in_ready returns to 1 the cycle after the DC-th output handshake.
- Throughput: 2·DC cycles per check with no backpressure.
- out_msg and out_idx are combinational from registered state. There is no combinational path from in_* to out_*.
- Boundary conditions:
  - in_valid while in EMIT: ignored; the message is not consumed.
  - out_ready while in COLLECT: ignored.
  - Reset mid-COLLECT or mid-EMIT: the partial check is discarded and all state returns to reset values immediately.
  - All DC magnitudes equal to 2^MAG_W-1: min1 = min2 = 2^MAG_W-1, idx = 0.

## Configuration
- CNU_OFFSET_EN:
  - Defined: output magnitude = (m > OFFSET) ? m-OFFSET : 0 (offset min-sum).
  - Undefined: output magnitude = m (plain min-sum), and OFFSET is unused.

## Test plan
All scenarios use DC=6, MAG_W=4, OFFSET=1, no backpressure unless stated.
- Magnitude selection:
  - Stimulus: magnitudes 5,3,7,2,9,4; signs all 0; hard decisions 1,0,1,1,0,0.
  - Required: out magnitudes 2,2,2,3,2,2 with out_idx 0..5; p_bit=1; with CNU_OFFSET_EN, magnitudes 1,1,1,2,1,1.
- Sign handling:
  - Stimulus: same magnitudes, only input 2 negative.
  - Required: out signs 1,1,0,1,1,1.
- Ties and saturation:
  - Stimulus: magnitudes 0,0,6,6,6,6.
  - Required: all out magnitudes 0, including index 0; with CNU_OFFSET_EN, still 0 (no wrap).
- Backpressure:
  - Stimulus: out_ready low for 3 cycles at j=2, with in_valid held high.
  - Required: out_msg and out_idx=2 held stable; in_ready=0 throughout; no inputs consumed.
- Reset mid-COLLECT:
  - Stimulus: rst pulsed after 3 inputs accepted, then a fresh 6-message check applied.
  - Required: output matches a fresh computation of the new 6 messages only; p_bit=0 immediately after reset.
- Back-to-back checks:
  - Stimulus: in_valid held high across two checks.
  - Required: in_ready=1 the cycle after the 6th output handshake; the second check's results are independent of the first (min registers reinitialised).
